cpu_mem_responder: RTL
======================

# cpu_mem_responder

Memory responder for the 8-bit RISC CPU: the slave end of the controller's memory strobes (`rd`, `wr`), holding program and data words. It returns registered read data one cycle after `rd` is sampled, commits exactly one write per `wr` assertion, and exposes a valid/ready loader port so a testbench or boot block can fill memory while the CPU is not accessing it. It sits between the address mux (PC/IR operand selected by `sel`) and the shared data bus.

## Interface
- `AWIDTH`, 5, address width; depth is 2**AWIDTH words
- `DWIDTH`, 8, data word width

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `addr`  in  AWIDTH  CPU address from the address mux
- `rd`  in  1  controller read strobe
- `wr`  in  1  controller write strobe
- `wdata`  in  DWIDTH  bus value driven by the accumulator when `data_e` is high
- `rdata`  out  DWIDTH  read data toward the bus
- `rdata_oe`  out  1  `rdata` valid; the bus mux selects memory when high
- `ld_valid`  in  1  loader word offered
- `ld_ready`  out  1  loader word accepted this cycle when `ld_valid` is also high
- `ld_addr`  in  AWIDTH  loader address
- `ld_data`  in  DWIDTH  loader data
- `par_err`  out  1  sticky parity error (see Configuration)

## Operation
- FSM states: IDLE, READ, WRITE_HOLD.
- IDLE: `rd`=1 → latch `mem[addr]` into `rdata`, `rdata_oe`=1, go to READ. `wr`=1 → write `wdata` to `mem[addr]`, go to WRITE_HOLD. `rd` and `wr` both high → write wins, `rdata_oe` stays 0.
- READ: each cycle `rdata` ← `mem[addr]`, so an address change under a held `rd` is tracked with one cycle of lag. `rd`=0 → `rdata_oe`=0 next cycle, go to IDLE. `wr`=1 → perform the write and go to WRITE_HOLD.
- WRITE_HOLD: no further writes. Return to IDLE when `wr`=0. Each `wr` high period, of any length, produces exactly one write.
- Loader: `ld_ready` = (state==IDLE) & !`rd` & !`wr`, combinational. On `ld_valid & ld_ready`, write `ld_data` to `mem[ld_addr]`. CPU strobes always win. A stalled loader holds `ld_valid`, `ld_addr` and `ld_data` stable.
- Memory array contents are not reset. Only the control registers are reset.

## Timing
- Reset values: `rdata`=0, `rdata_oe`=0, `par_err`=0, state=IDLE. `ld_ready` follows its equation once `rst_n` is high.
- Read latency is 1 cycle. `rd` sampled high at edge N gives valid `rdata` after edge N. The controller raises `rd` in phase 1, so data is valid in phases 2–3 for `ld_ir`, and in phases 6–7 for `ld_ac`.
- Writes commit at the first rising edge where `wr` is high. The controller holds `wr` for phase 7 only.
- A read of an address written in the previous cycle returns the new data; there is no bypass hazard.
- Reset asserted mid-access: state goes to IDLE and `rdata_oe` to 0 immediately, with no clock needed. A write whose edge has not yet occurred is dropped.

## Configuration
- `CPU_MEM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit, computed on both CPU and loader writes.
  - Every read (READ-state update) checks the parity. A mismatch sets `par_err`, which stays set until reset.
- `CPU_MEM_PARITY_EN` undefined: no parity storage, and `par_err` is tied to 0.

## Structure
- Shared package `cpu_pkg`: the opcode constants (HLT…JMP), `AWIDTH`/`DWIDTH` defaults, and the `mem_state_t` enum (IDLE/READ/WRITE_HOLD).
- One sub-module, `cpu_mem_array`: single-write, single-read storage with an optional parity column. The FSM, loader arbitration and parity checking stay in the top module.

## Test plan
- Reset, then load 0x3C to address 5 via the loader with `rd`/`wr` low → `ld_ready`=1 and the word is accepted. Then `rd`=1, `addr`=5 → `rdata`=0x3C with `rdata_oe`=1 one cycle later.
- `wr`=1 held for 3 cycles, `addr`=7, `wdata` changing 0x11→0x22→0x33 → `mem[7]`=0x11 (one write only), and the state returns to IDLE after `wr` drops.
- `ld_valid`=1 while `rd`=1 → `ld_ready`=0 and no loader write occurs. Deassert `rd` → `ld_ready`=1 the next cycle and the word is accepted.
- `rd` held while `addr` steps 2→3, with `mem[2]`=0xA5 and `mem[3]`=0x5A → `rdata` shows 0xA5, then 0x5A one cycle after the address change.
- Assert `rst_n`=0 during READ → `rdata_oe` and `rdata` go to 0 immediately. Previously loaded contents are still readable after reset.
- With `CPU_MEM_PARITY_EN`: force a stored parity bit wrong at address 4, then read it → `par_err`=1 and stays 1 through later good reads until reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: opcodes, default widths and
// the memory responder state encoding.
package cpu_pkg;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   localparam int CPU_AWIDTH = 5;
   localparam int CPU_DWIDTH = 8;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      READ       = 2'd1,
      WRITE_HOLD = 2'd2
   } mem_state_t;

endpackage

// File: rtl/cpu_mem_array.sv
// Single-write, asynchronous-read word storage. Word width WW includes the
// parity column when the top builds with CPU_MEM_PARITY_EN. Contents are not reset.
module cpu_mem_array #(
   parameter int AWIDTH = 5,
   parameter int WW     = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AWIDTH-1:0] waddr,
   input  logic [WW-1:0]     wword,
   input  logic [AWIDTH-1:0] raddr,
   output logic [WW-1:0]     rword
);

   logic [WW-1:0] mem_q [2**AWIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wword;
      end
   end

   assign rword = mem_q[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// CPU memory slave: rd/wr strobe FSM, idle-time loader port, registered read data.
// Optional even-parity column and sticky par_err when CPU_MEM_PARITY_EN is defined.
module cpu_mem_responder
   import cpu_pkg::*;
#(
   parameter int AWIDTH = CPU_AWIDTH,
   parameter int DWIDTH = CPU_DWIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AWIDTH-1:0] addr,
   input  logic              rd,
   input  logic              wr,
   input  logic [DWIDTH-1:0] wdata,
   output logic [DWIDTH-1:0] rdata,
   output logic              rdata_oe,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [AWIDTH-1:0] ld_addr,
   input  logic [DWIDTH-1:0] ld_data,
   output logic              par_err
);

`ifdef CPU_MEM_PARITY_EN
   localparam int WW = DWIDTH + 1;
`else
   localparam int WW = DWIDTH;
`endif

   function automatic logic [WW-1:0] make_word(input logic [DWIDTH-1:0] d);
`ifdef CPU_MEM_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   mem_state_t        state_q, state_d;
   logic [DWIDTH-1:0] rdata_q, rdata_d;
   logic              rdata_oe_q, rdata_oe_d;
   logic              we;
   logic [AWIDTH-1:0] waddr;
   logic [WW-1:0]     wword;
   logic [WW-1:0]     rword;
   logic              rd_latch;

   assign ld_ready = (state_q == IDLE) && !rd && !wr;

   always_comb begin
      state_d    = state_q;
      rdata_d    = rdata_q;
      rdata_oe_d = rdata_oe_q;
      we         = 1'b0;
      waddr      = addr;
      wword      = make_word(wdata);
      rd_latch   = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Write beats read when both strobes arrive together.
            if (wr) begin
               we         = 1'b1;
               rdata_oe_d = 1'b0;
               state_d    = WRITE_HOLD;
            end else if (rd) begin
               rd_latch   = 1'b1;
               state_d    = READ;
            end else if (ld_valid) begin
               we    = 1'b1;
               waddr = ld_addr;
               wword = make_word(ld_data);
            end
         end
         READ: begin
            if (wr) begin
               we         = 1'b1;
               rdata_oe_d = 1'b0;
               state_d    = WRITE_HOLD;
            end else if (rd) begin
               rd_latch = 1'b1;
            end else begin
               rdata_oe_d = 1'b0;
               state_d    = IDLE;
            end
         end
         WRITE_HOLD: begin
            rdata_oe_d = 1'b0;
            if (!wr) begin
               state_d = IDLE;
            end
         end
         default: begin
            rdata_oe_d = 1'b0;
            state_d    = IDLE;
         end
      endcase
      if (rd_latch) begin
         rdata_d    = rword[DWIDTH-1:0];
         rdata_oe_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rdata_q    <= '0;
         rdata_oe_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rdata_q    <= rdata_d;
         rdata_oe_q <= rdata_oe_d;
      end
   end

`ifdef CPU_MEM_PARITY_EN
   logic par_err_q, par_err_d;

   // A stored word with odd overall parity has been corrupted.
   always_comb begin
      par_err_d = par_err_q | (rd_latch & (^rword));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= par_err_d;
      end
   end

   assign par_err = par_err_q;
`else
   assign par_err = 1'b0;
`endif

   assign rdata    = rdata_q;
   assign rdata_oe = rdata_oe_q;

   cpu_mem_array #(
      .AWIDTH (AWIDTH),
      .WW     (WW)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wword (wword),
      .raddr (addr),
      .rword (rword)
   );

endmodule
